// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control FSM: opcodes, functs, state
// encodings, ALU operation codes and the decoded-instruction record.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_J   = 3'd4,
    CLS_IMM = 3'd5
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [2:0]   alu_op;
    logic         alu_src;
    logic         legal;
  } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> class, ALU op, ALU source
// select and a legality flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_fn,
  output decode_t    o_dec
);

  // Opcode/funct lookup; anything unlisted is flagged illegal.
  always_comb begin
    o_dec.cls     = CLS_R;
    o_dec.alu_op  = ALU_ADD;
    o_dec.alu_src = 1'b0;
    o_dec.legal   = 1'b1;
    case (i_op)
      OP_RTYPE: begin
        case (i_fn)
          FN_ADD:  o_dec.alu_op = ALU_ADD;
          FN_SUB:  o_dec.alu_op = ALU_SUB;
          FN_AND:  o_dec.alu_op = ALU_AND;
          FN_OR:   o_dec.alu_op = ALU_OR;
          FN_SLT:  o_dec.alu_op = ALU_SLT;
          default: o_dec.legal  = 1'b0;
        endcase
      end
      OP_LW:   begin o_dec.cls = CLS_LW;  o_dec.alu_src = 1'b1; end
      OP_SW:   begin o_dec.cls = CLS_SW;  o_dec.alu_src = 1'b1; end
      OP_BEQ:  begin o_dec.cls = CLS_BEQ; o_dec.alu_op = ALU_SUB; end
      OP_J:    o_dec.cls = CLS_J;
      OP_ADDI: begin o_dec.cls = CLS_IMM; o_dec.alu_src = 1'b1; end
      OP_ORI:  begin o_dec.cls = CLS_IMM; o_dec.alu_op = ALU_OR;  o_dec.alu_src = 1'b1; end
      OP_LUI:  begin o_dec.cls = CLS_IMM; o_dec.alu_op = ALU_LUI; o_dec.alu_src = 1'b1; end
      default: o_dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset core,
// with a sticky trap on illegal instructions and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             ct_branch,
  output logic             ct_jump,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic [CNT_W-1:0] r_cnt;
  decode_t          w_dec;

  ctrl_decode u_decode (
    .i_op  (r_op),
    .i_fn  (r_fn),
    .o_dec (w_dec)
  );

  // Next-state and strobe logic; pc_we in MEM follows dmem_ready, the rest is state-driven.
  always_comb begin
    w_next     = r_state;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    ct_branch  = 1'b0;
    ct_jump    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_dec.legal && (w_dec.cls == CLS_J)) begin
          pc_we   = 1'b1;
          ct_jump = 1'b1;
          w_next  = S_FETCH;
        end else if (!w_dec.legal) begin
          if (TRAP_EN) begin
            w_next = S_TRAP;
          end else begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = w_dec.alu_op;
        alu_src = w_dec.alu_src;
        if (w_dec.cls == CLS_BEQ) begin
          pc_we     = 1'b1;
          ct_branch = 1'b1;
          w_next    = S_FETCH;
        end else if ((w_dec.cls == CLS_LW) || (w_dec.cls == CLS_SW)) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_re = (w_dec.cls == CLS_LW);
        mem_we = (w_dec.cls == CLS_SW);
        if (dmem_ready) begin
          if (w_dec.cls == CLS_LW) begin
            w_next = S_WB;
          end else begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        reg_dst    = (w_dec.cls == CLS_R);
        mem_to_reg = (w_dec.cls == CLS_LW);
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction fields are latched once; all later decode works from these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= 6'd0;
      r_fn <= 6'd0;
    end else if (ir_we) begin
      r_op <= opcode;
      r_fn <= funct;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (pc_we) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state      = r_state;
  assign retire_cnt = r_cnt;

endmodule
